decoder_core: RTL and testbench
===============================

DECODER_CORE -- requirements
Module: decoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports are named clk_i and rst_ni.
REQ-002 Port clk_i: input, 1 bit, clock; all state updates on its rising edge.
REQ-003 Port rst_ni: input, 1 bit, synchronous active-low reset, sampled on the rising edge of clk_i.
REQ-004 Port valid_i: input, 1 bit, instr_i carries an instruction this cycle.
REQ-005 Port instr_i: input, 32 bits, RV32I instruction word.
REQ-006 Port valid_o: output, 1 bit, registered decode outputs are valid.
REQ-007 Port opcode_o: output, 7 bits, instr[6:0].
REQ-008 Port funct3_o: output, 3 bits, instr[14:12].
REQ-009 Port funct7_o: output, 7 bits, instr[31:25].
REQ-010 Port rd_addr_o, rs1_addr_o, rs2_addr_o: outputs, 5 bits each, instr[11:7], instr[19:15], instr[24:20].
REQ-011 Port imm_o: output, 32 bits, sign-extended immediate for the decoded format.
REQ-012 Port fmt_o: output, 6 bits one-hot, {R,I,S,B,U,J} = bits 5..0.
REQ-013 Port illegal_o: output, 1 bit, opcode not in the RV32I base set.

Function
REQ-014 All outputs SHALL be registered; latency 1 cycle: values from instr_i/valid_i sampled at edge N appear after edge N.
REQ-015 The block SHALL capture a new instruction every cycle valid_i=1 (throughput 1/cycle, no backpressure).
REQ-016 When valid_i=0, valid_o SHALL go 0 on the next edge; all other outputs SHALL hold their previous values.
REQ-017 Field outputs (opcode, funct3, funct7, rd, rs1, rs2) SHALL be the raw bit slices regardless of format.
REQ-018 Format mapping: R=0110011; I=0010011, 0000011, 1100111, 1110011, 0001111; S=0100011; B=1100011; U=0110111, 0010111; J=1101111.
REQ-019 I-imm SHALL be sext(instr[31:20]).
REQ-020 S-imm SHALL be sext({instr[31:25],instr[11:7]}).
REQ-021 B-imm SHALL be sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}); bit0 always 0.
REQ-022 U-imm SHALL be {instr[31:12],12'h000}.
REQ-023 J-imm SHALL be sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
REQ-024 R-type and illegal opcodes SHALL give imm_o=0; illegal opcodes SHALL give fmt_o=0 and illegal_o=1.
REQ-025 Sign extension SHALL replicate instr[31] into all upper bits (e.g. imm -1 -> 32'hFFFFFFFF).
REQ-026 illegal_o SHALL be set only from the opcode; funct3/funct7 are not checked.

Reset
REQ-027 With rst_ni=0 at a rising edge, all outputs SHALL become 0 (valid_o=0, fmt_o=0, illegal_o=0, imm_o=0); reset wins over valid_i.
REQ-028 The first instruction captured in the cycle after rst_ni returns high SHALL decode normally with 1-cycle latency.

Verification
REQ-029 ADDI x1,x1,4 (32'h00408093), valid_i=1 -> next cycle opcode 0010011, rd 1, rs1 1, imm 32'h4, fmt I, valid_o 1.
REQ-030 SW x2,4(x0) (32'h00202223) -> opcode 0100011, rs1 0, rs2 2, imm 32'h4, fmt S.
REQ-031 BEQ x0,x0,8 (32'h00000463) -> opcode 1100011, rs1 0, rs2 0, funct3 0, imm 32'h8, fmt B; BEQ -4 (32'hFE000EE3) -> imm 32'hFFFFFFFC.
REQ-032 LUI x2,0x1 (32'h00001137) -> opcode 0110111, rd 2, imm 32'h00001000, fmt U; JAL x0,0 (32'h0000006F) -> opcode 1101111, rd 0, imm 0, fmt J.
REQ-033 Opcode 1111111 (32'h0000007F) -> illegal_o 1, fmt_o 0, imm_o 0; next valid legal instruction clears illegal_o.
REQ-034 Back-to-back valid instructions, then valid_i=0, then rst_ni=0 mid-stream -> each decoded one cycle later, valid_o drops with held fields, all outputs zero after the reset edge.

Source files
------------

// File: rtl/decoder_core.sv
// rtl/decoder_core.sv - RV32I instruction decoder with registered field, immediate and format outputs
module decoder_core (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic [31:0] instr_i,
    output logic        valid_o,
    output logic [6:0]  opcode_o,
    output logic [2:0]  funct3_o,
    output logic [6:0]  funct7_o,
    output logic [4:0]  rd_addr_o,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    output logic [31:0] imm_o,
    output logic [5:0]  fmt_o,
    output logic        illegal_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // One-hot format encoding, bit positions {R,I,S,B,U,J} = 5..0
    localparam logic [5:0] FMT_R = 6'b100000;
    localparam logic [5:0] FMT_I = 6'b010000;
    localparam logic [5:0] FMT_S = 6'b001000;
    localparam logic [5:0] FMT_B = 6'b000100;
    localparam logic [5:0] FMT_U = 6'b000010;
    localparam logic [5:0] FMT_J = 6'b000001;

    logic [6:0]  opcode;
    logic        sign;
    logic [5:0]  fmt_d;
    logic [31:0] imm_d;
    logic        illegal_d;

    logic        valid_q;
    logic [6:0]  opcode_q;
    logic [2:0]  funct3_q;
    logic [6:0]  funct7_q;
    logic [4:0]  rd_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [31:0] imm_q;
    logic [5:0]  fmt_q;
    logic        illegal_q;

    assign opcode = instr_i[6:0];
    assign sign   = instr_i[31];

    // Classify the opcode and assemble the sign-extended immediate for its format
    always_comb begin
        fmt_d     = 6'b000000;
        imm_d     = 32'h0000_0000;
        illegal_d = 1'b0;
        case (opcode)
            OP_R: begin
                fmt_d = FMT_R;
            end
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: begin
                fmt_d = FMT_I;
                imm_d = {{20{sign}}, instr_i[31:20]};
            end
            OP_STORE: begin
                fmt_d = FMT_S;
                imm_d = {{20{sign}}, instr_i[31:25], instr_i[11:7]};
            end
            OP_BRANCH: begin
                fmt_d = FMT_B;
                imm_d = {{19{sign}}, instr_i[31], instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt_d = FMT_U;
                imm_d = {instr_i[31:12], 12'h000};
            end
            OP_JAL: begin
                fmt_d = FMT_J;
                imm_d = {{11{sign}}, instr_i[31], instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
            end
            default: begin
                illegal_d = 1'b1;
            end
        endcase
    end

    // Output registers: clear on reset, capture on valid, otherwise hold fields and drop valid
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            opcode_q  <= 7'd0;
            funct3_q  <= 3'd0;
            funct7_q  <= 7'd0;
            rd_q      <= 5'd0;
            rs1_q     <= 5'd0;
            rs2_q     <= 5'd0;
            imm_q     <= 32'd0;
            fmt_q     <= 6'd0;
            illegal_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                opcode_q  <= opcode;
                funct3_q  <= instr_i[14:12];
                funct7_q  <= instr_i[31:25];
                rd_q      <= instr_i[11:7];
                rs1_q     <= instr_i[19:15];
                rs2_q     <= instr_i[24:20];
                imm_q     <= imm_d;
                fmt_q     <= fmt_d;
                illegal_q <= illegal_d;
            end
        end
    end

    assign valid_o    = valid_q;
    assign opcode_o   = opcode_q;
    assign funct3_o   = funct3_q;
    assign funct7_o   = funct7_q;
    assign rd_addr_o  = rd_q;
    assign rs1_addr_o = rs1_q;
    assign rs2_addr_o = rs2_q;
    assign imm_o      = imm_q;
    assign fmt_o      = fmt_q;
    assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_decoder_core.sv
// tb/tb_decoder_core.sv - scoreboard bench for decoder_core
module tb_decoder_core;

    typedef struct {
        logic        valid;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [5:0]  fmt;
        logic        ill;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic [31:0] instr_i;
    logic        valid_o;
    logic [6:0]  opcode_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o;
    logic [4:0]  rd_addr_o;
    logic [4:0]  rs1_addr_o;
    logic [4:0]  rs2_addr_o;
    logic [31:0] imm_o;
    logic [5:0]  fmt_o;
    logic        illegal_o;

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb_q[$];
    exp_t last_exp;

    decoder_core dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid_i    (valid_i),
        .instr_i    (instr_i),
        .valid_o    (valid_o),
        .opcode_o   (opcode_o),
        .funct3_o   (funct3_o),
        .funct7_o   (funct7_o),
        .rd_addr_o  (rd_addr_o),
        .rs1_addr_o (rs1_addr_o),
        .rs2_addr_o (rs2_addr_o),
        .imm_o      (imm_o),
        .fmt_o      (fmt_o),
        .illegal_o  (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.valid = 1'b0; e.opcode = '0; e.funct3 = '0; e.funct7 = '0;
        e.rd = '0; e.rs1 = '0; e.rs2 = '0; e.imm = '0; e.fmt = '0; e.ill = 1'b0;
        return e;
    endfunction

    function automatic exp_t make_exp(input logic [31:0] ins, input logic [31:0] imm,
                                      input logic [5:0] fmt, input logic ill);
        exp_t e;
        e.valid  = 1'b1;
        e.opcode = ins[6:0];
        e.funct3 = ins[14:12];
        e.funct7 = ins[31:25];
        e.rd     = ins[11:7];
        e.rs1    = ins[19:15];
        e.rs2    = ins[24:20];
        e.imm    = imm;
        e.fmt    = fmt;
        e.ill    = ill;
        return e;
    endfunction

    // Reference format: bit index R=5 .. J=0
    function automatic logic [5:0] ref_fmt(input logic [6:0] op);
        if (op == 7'h33) return 6'd1 << 5;
        if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73 || op == 7'h0F) return 6'd1 << 4;
        if (op == 7'h23) return 6'd1 << 3;
        if (op == 7'h63) return 6'd1 << 2;
        if (op == 7'h37 || op == 7'h17) return 6'd1 << 1;
        if (op == 7'h6F) return 6'd1;
        return 6'd0;
    endfunction

    // Reference immediate: left-justify the field, then arithmetic-shift it back down
    function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [5:0] fmt);
        logic signed [31:0] s;
        case (fmt)
            6'b010000: begin s = ins; s = s >>> 20; end
            6'b001000: begin s = {ins[31:25], ins[11:7], 20'b0}; s = s >>> 20; end
            6'b000100: begin s = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 19'b0}; s = s >>> 19; end
            6'b000010: s = ins & 32'hFFFF_F000;
            6'b000001: begin s = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 11'b0}; s = s >>> 11; end
            default:   s = 32'sd0;
        endcase
        return s;
    endfunction

    task automatic compare_one();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check_eq("valid",   {31'd0, valid_o},     {31'd0, e.valid});
        check_eq("opcode",  {25'd0, opcode_o},    {25'd0, e.opcode});
        check_eq("funct3",  {29'd0, funct3_o},    {29'd0, e.funct3});
        check_eq("funct7",  {25'd0, funct7_o},    {25'd0, e.funct7});
        check_eq("rd",      {27'd0, rd_addr_o},   {27'd0, e.rd});
        check_eq("rs1",     {27'd0, rs1_addr_o},  {27'd0, e.rs1});
        check_eq("rs2",     {27'd0, rs2_addr_o},  {27'd0, e.rs2});
        check_eq("imm",     imm_o,                e.imm);
        check_eq("fmt",     {26'd0, fmt_o},       {26'd0, e.fmt});
        check_eq("illegal", {31'd0, illegal_o},   {31'd0, e.ill});
    endtask

    // Drive one cycle, record what the outputs must show after the edge, then compare
    task automatic step(input logic rst, input logic vld, input logic [31:0] ins, input exp_t dec);
        @(negedge clk_i);
        rst_ni  = rst;
        valid_i = vld;
        instr_i = ins;
        if (!rst)      last_exp = zero_exp();
        else if (vld)  last_exp = dec;
        else           last_exp.valid = 1'b0;
        sb_q.push_back(last_exp);
        @(posedge clk_i);
        #1;
        compare_one();
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] imm, input logic [5:0] fmt, input logic ill);
        step(1'b1, 1'b1, ins, make_exp(ins, imm, fmt, ill));
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 32'hDEAD_BEEF, zero_exp());
    endtask

    task automatic do_reset(input logic vld, input logic [31:0] ins);
        step(1'b0, vld, ins, zero_exp());
    endtask

    logic [6:0] op_pool [12] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F,
                                7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h5B};

    initial begin
        logic [31:0] r;
        logic [31:0] ins;
        logic [5:0]  f;
        rst_ni   = 1'b0;
        valid_i  = 1'b0;
        instr_i  = 32'd0;
        last_exp = zero_exp();

        // Reset wins over a valid instruction
        do_reset(1'b1, 32'h0040_8093);
        do_reset(1'b1, 32'h0040_8093);

        // Directed vectors, back to back; first one right after reset release
        send(32'h0040_8093, 32'h0000_0004, 6'b010000, 1'b0); // ADDI x1,x1,4
        send(32'h0020_2223, 32'h0000_0004, 6'b001000, 1'b0); // SW x2,4(x0)
        send(32'h0000_0463, 32'h0000_0008, 6'b000100, 1'b0); // BEQ +8
        send(32'hFE00_0EE3, 32'hFFFF_FFFC, 6'b000100, 1'b0); // BEQ -4
        send(32'h0000_1137, 32'h0000_1000, 6'b000010, 1'b0); // LUI x2,0x1
        send(32'h0000_006F, 32'h0000_0000, 6'b000001, 1'b0); // JAL x0,0
        send(32'h0000_007F, 32'h0000_0000, 6'b000000, 1'b1); // illegal
        send(32'h0040_8093, 32'h0000_0004, 6'b010000, 1'b0); // clears illegal
        send(32'hFFF0_0093, 32'hFFFF_FFFF, 6'b010000, 1'b0); // ADDI x1,x0,-1
        send(32'h4020_8133, 32'h0000_0000, 6'b100000, 1'b0); // SUB: R-type imm 0
        send(32'hFFDF_F06F, 32'hFFFF_FFFC, 6'b000001, 1'b0); // JAL x0,-4
        send(32'hFFFF_F0B7, 32'hFFFF_F000, 6'b000010, 1'b0); // LUI negative
        send(32'hFFFF_FFFF, 32'h0000_0000, 6'b000000, 1'b1); // illegal, all ones
        send(32'hFE20_AE23, 32'hFFFF_FFFC, 6'b001000, 1'b0); // SW x2,-4(x1)

        // Idle cycles: valid drops, fields hold
        idle();
        idle();

        // Randomised opcodes from the base set plus an illegal one
        for (int k = 0; k < 40; k++) begin
            r   = $urandom();
            ins = {r[31:7], op_pool[$urandom_range(0, 11)]};
            f   = ref_fmt(ins[6:0]);
            send(ins, ref_imm(ins, f), f, (f == 6'd0));
            if ($urandom_range(0, 3) == 0) idle();
        end

        // Reset mid-stream with valid held high, then normal decode resumes
        send(32'h0000_0463, 32'h0000_0008, 6'b000100, 1'b0);
        do_reset(1'b1, 32'h0020_2223);
        send(32'h0000_1137, 32'h0000_1000, 6'b000010, 1'b0);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
